// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative RV32M multiply/divide unit for the execute stage.
//                Shift-add multiply or restoring divide over XLEN cycles on
//                operand magnitudes, with sign fix-up at completion.
//                Latency is fixed: start sampled at edge k gives done=1 in
//                the cycle after edge k+XLEN.
//  Ports       : clk     - clock, all state on rising edge
//                rst_n   - synchronous active-low reset
//                start   - E-stage holds an M-extension op
//                kill    - abort current op (E-stage flush)
//                funct3  - M-extension operation select
//                srcA    - rs1 operand
//                srcB    - rs2 operand
//                result  - registered result, valid while done=1
//                done    - one-cycle completion pulse
//                busy    - high while iterating
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     bmag_q;     // multiplicand / divisor magnitude
    logic [XLEN-1:0]     araw_q;     // srcA as latched, for REM by zero
    logic                a_neg_q;
    logic                b_neg_q;
    logic                b_zero_q;
    logic [XLEN-1:0]     result_q;
    logic                done_q;
    logic                busy_q;

    // ------------------------------------------------------------------
    // Operand capture: sign flags and magnitudes
    // ------------------------------------------------------------------
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    // MUL yields the same low word either way; treat it as signed.
    assign a_signed = (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
    assign b_signed = (funct3 == F_MUL) || (funct3 == F_MULH) ||
                      (funct3 == F_DIV) || (funct3 == F_REM);
    assign a_neg    = a_signed && srcA[XLEN-1];
    assign b_neg    = b_signed && srcB[XLEN-1];
    // -2^(XLEN-1) negates to itself, which is the correct unsigned magnitude.
    assign a_mag    = a_neg ? (-srcA) : srcA;
    assign b_mag    = b_neg ? (-srcB) : srcB;

    // ------------------------------------------------------------------
    // One multiply iteration: conditional add into the high half, then
    // shift the whole accumulator right by one (carry enters at the top).
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      ({1'b0, bmag_q} & {(XLEN+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // ------------------------------------------------------------------
    // One restoring-divide iteration. The partial remainder is always
    // below the divisor, so the shifted value is below twice the divisor
    // and the top bit of the trial difference is a clean borrow flag.
    // ------------------------------------------------------------------
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, bmag_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] acc_d;
    assign acc_d = op_q[2] ? div_next : mul_next;

    // ------------------------------------------------------------------
    // Sign fix-up and result select, applied to the final iteration.
    // The signed overflow case (-2^(XLEN-1) / -1) falls out naturally:
    // magnitudes give quotient 2^(XLEN-1), remainder 0, same signs.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   result_d;

    assign prod_s = (a_neg_q ^ b_neg_q) ? (-acc_d) : acc_d;
    assign quot_s = (a_neg_q ^ b_neg_q) ? (-acc_d[XLEN-1:0]) : acc_d[XLEN-1:0];
    assign rem_s  = a_neg_q ? (-acc_d[2*XLEN-1:XLEN]) : acc_d[2*XLEN-1:XLEN];

    always_comb begin
        result_d = '0;
        case (op_q)
            F_MUL:                     result_d = prod_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             result_d = b_zero_q ? {XLEN{1'b1}} : quot_s;
            F_REM, F_REMU:             result_d = b_zero_q ? araw_q : rem_s;
            default:                   result_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            araw_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !kill) begin
                        op_q     <= funct3;
                        acc_q    <= {{XLEN{1'b0}}, a_mag};
                        bmag_q   <= b_mag;
                        araw_q   <= srcA;
                        a_neg_q  <= a_neg;
                        b_neg_q  <= b_neg;
                        b_zero_q <= (srcB == '0);
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                        busy_q   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            result_q <= result_d;
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not re-sampled here.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
- Accepts an M-extension op when the E-stage "is M-op" flag (`start`) is high.
- Runs a fixed-latency shift-add multiply or restoring divide over XLEN cycles.
- Drives `done`, which the hazard unit uses to hold F/D/E/M while the op runs. The result is muxed into the E-stage result path when `done` is high.

Parameters:
- XLEN, 32, operand/result width. Also the iteration count.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  E-stage instruction is an M-extension op; held high while stalled.
- kill  input  1  abort the current op (E-stage flush).
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA  input  XLEN  rs1 operand (post-forwarding).
- srcB  input  XLEN  rs2 operand (post-forwarding).
- result  output  XLEN  registered result; valid only while done=1.
- done  output  1  result valid this cycle; high exactly one cycle per completed op.
- busy  output  1  high in BUSY state (debug/perf counter).

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low: rst_n=0 sampled at a rising edge gives state=IDLE, done=0, busy=0, result=0, counter=0, internal accumulators=0.
  - Reset has priority over everything, including mid-operation; the op in flight is discarded.
- FSM states: IDLE, BUSY, DONE. `done` = (state==DONE); `busy` = (state==BUSY).
- IDLE:
  - If start=1 and kill=0 at an edge: latch funct3 and operand magnitudes plus sign flags, set counter=0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - One iteration per edge, counter incremented each edge.
  - After the XLEN-th iteration (counter==XLEN-1 at the edge), apply the sign fix-up, register `result`, go to DONE.
  - srcA, srcB and funct3 are ignored after latching.
- DONE:
  - `done`=1 for exactly this cycle.
  - Unconditionally return to IDLE at the next edge. A held `start` is not re-sampled in DONE.
- Latency:
  - start first sampled at edge k gives done=1 during the cycle after edge k+XLEN (XLEN+1 cycles of stall).
  - This is uniform for all funct3 and operand values, including special cases.
- Back-to-back ops:
  - After DONE→IDLE, a new start is sampled at the following edge.
  - The next instruction therefore sees one IDLE cycle with done=0, which correctly keeps the pipeline stalled.
- kill:
  - kill=1 at an edge in BUSY or DONE forces IDLE; the `result` register is unchanged.
  - kill=1 in IDLE blocks start.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*XLEN product.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - Negate the product if the operand signs differ.
  - MUL returns product[XLEN-1:0]; the MULH* ops return product[2XLEN-1:XLEN].
- Divide:
  - Restoring divide on magnitudes; DIV/REM are signed.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Special cases, overriding the normal result at completion:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give srcA as latched.
  - DIV with -2^(XLEN-1) / -1: result = 0x80000000; REM = 0.
- Result width: all arithmetic is modulo 2^XLEN at the output.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3) → done one cycle only, exactly 33 cycles after start first sampled; result 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Back-to-back: MUL then DIVU 100/7 with start held high across both → two done pulses separated by one IDLE cycle plus a 33-cycle op; results 0xFFFFFFEB then 14. Operands changed mid-BUSY do not affect the result.
- kill asserted at cycle 10 of BUSY → IDLE next cycle, no done pulse, result unchanged. A fresh MUL 3×4 afterwards gives 12 with full latency.
- rst_n=0 for one edge mid-BUSY → done=0, busy=0, result=0 next cycle. start held high with rst_n=0 is ignored; after rst_n=1, the op restarts from counter 0.
